// File: rtl/uart_bus_pkg.sv
// Shared command codes and state encodings for the UART bus master.
package uart_bus_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    CmdIdle,
    CmdAddrHi,
    CmdAddrLo,
    CmdData,
    CmdBusReq,
    CmdBusCycle,
    CmdBusWait,
    CmdResp
  } cmd_state_e;

  // Bit-level framing state, shared by receiver and transmitter.
  typedef enum logic [1:0] {
    BitIdle,
    BitStart,
    BitData,
    BitStop
  } bit_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with glitch rejection, framing check and a one-deep holding register.
module uart_rx_core
  import uart_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 235
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       consume,
  output logic [7:0] data,
  output logic       valid
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            rx_s;
  bit_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            wait_high_q, wait_high_d;  // set after a framing error until the line idles

  assign rx_s  = sync_q[1];
  assign data  = data_q;
  assign valid = valid_q;

  // Two-flop synchronizer on the asynchronous serial input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end

  // Receiver state and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BitIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      wait_high_q <= wait_high_d;
    end
  end

  // Next-state: start/glitch check, mid-bit sampling, stop-bit validation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~consume;
    wait_high_d = wait_high_q;
    unique case (state_q)
      BitIdle: begin
        cnt_d = '0;
        if (wait_high_q) begin
          if (rx_s) wait_high_d = 1'b0;
        end else if (!rx_s) begin
          state_d = BitStart;
        end
      end
      BitStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? BitIdle : BitData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BitData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = BitStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BitStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = BitIdle;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            wait_high_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BitIdle;
    endcase
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes W/R command frames and runs single bus cycles.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 235,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uartRx,
  output logic        uartTx,
  output logic        busReq,
  input  logic        busGrant,
  output logic [15:0] AB,
  output logic [7:0]  DO,
  input  logic [7:0]  DI,
  output logic        CS,
  output logic        WE,
  output logic        active
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 2;
  localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_consume;

  cmd_state_e      state_q, state_d;
  logic            write_q, write_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rsp_q, rsp_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [15:0]     ab_q, ab_d;
  logic [7:0]      do_q, do_d;
  logic [ToW-1:0]  to_cnt_q;
  logic            in_frame;
  logic            timed_out;
  logic            tx_start;

  bit_state_e      tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rx      (uartRx),
    .consume (rx_consume),
    .data    (rx_data),
    .valid   (rx_valid)
  );

  assign in_frame  = (state_q == CmdAddrHi) || (state_q == CmdAddrLo) || (state_q == CmdData);
  assign timed_out = (to_cnt_q == ToLast);

  assign uartTx = tx_line_q;
  assign busReq = (state_q == CmdBusReq) || (state_q == CmdBusCycle) || (state_q == CmdBusWait);
  assign CS     = (state_q == CmdBusCycle);
  assign WE     = CS & write_q;
  assign AB     = ab_q;
  assign DO     = do_q;
  assign active = (state_q != CmdIdle);

  // Inter-byte idle counter; cleared on every consumed byte and outside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     to_cnt_q <= '0;
    else if (in_frame && !rx_valid) to_cnt_q <= to_cnt_q + 1'b1;
    else                           to_cnt_q <= '0;
  end

  // Command FSM and bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CmdIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      lat_q   <= '0;
      ab_q    <= '0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      lat_q   <= lat_d;
      ab_q    <= ab_d;
      do_q    <= do_d;
    end
  end

  // Command decode, bus handshake and response hand-off to the transmitter.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    lat_d      = lat_q;
    ab_d       = ab_q;
    do_d       = do_q;
    rx_consume = 1'b0;
    tx_start   = 1'b0;
    unique case (state_q)
      CmdIdle: begin
        if (rx_valid) begin
          rx_consume = 1'b1;
          if (rx_data == CMD_WRITE) begin
            write_d = 1'b1;
            state_d = CmdAddrHi;
          end else if (rx_data == CMD_READ) begin
            write_d = 1'b0;
            state_d = CmdAddrHi;
          end else begin
            rsp_d   = RSP_ERR;
            state_d = CmdResp;
          end
        end
      end
      CmdAddrHi: begin
        if (rx_valid) begin
          rx_consume   = 1'b1;
          addr_d[15:8] = rx_data;
          state_d      = CmdAddrLo;
        end else if (timed_out) begin
          state_d = CmdIdle;
        end
      end
      CmdAddrLo: begin
        if (rx_valid) begin
          rx_consume  = 1'b1;
          addr_d[7:0] = rx_data;
          state_d     = write_q ? CmdData : CmdBusReq;
        end else if (timed_out) begin
          state_d = CmdIdle;
        end
      end
      CmdData: begin
        if (rx_valid) begin
          rx_consume = 1'b1;
          wdata_d    = rx_data;
          state_d    = CmdBusReq;
        end else if (timed_out) begin
          state_d = CmdIdle;
        end
      end
      CmdBusReq: begin
        if (busGrant) begin
          ab_d    = addr_q;
          if (write_q) do_d = wdata_q;
          state_d = CmdBusCycle;
        end
      end
      CmdBusCycle: begin
        lat_d   = '0;
        state_d = CmdBusWait;
      end
      CmdBusWait: begin
        if (write_q) begin
          rsp_d   = RSP_OK;
          state_d = CmdResp;
        end else if (lat_q == LatLast) begin
          rsp_d   = DI;
          state_d = CmdResp;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      CmdResp: begin
        if (tx_state_q == BitIdle) begin
          tx_start = 1'b1;
          state_d  = CmdIdle;
        end
      end
      default: state_d = CmdIdle;
    endcase
  end

  // Transmitter registers; the line itself is registered so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= BitIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Transmit sequencing: start, 8 data bits LSB first, stop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    unique case (tx_state_q)
      BitIdle: begin
        tx_line_d = 1'b1;
        tx_cnt_d  = '0;
        if (tx_start) begin
          tx_shift_d = rsp_q;
          tx_line_d  = 1'b0;
          tx_state_d = BitStart;
        end
      end
      BitStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = BitData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      BitData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = BitStop;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
            tx_idx_d   = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      BitStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_state_d = BitIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = BitIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART command frames in, bus cycles and responses out.
module tb_uart_bus_master;

  localparam int unsigned CPB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uartRx = 1'b1;
  logic        busGrant = 1'b0;
  logic [7:0]  DI = 8'hEE;
  logic        uartTx;
  logic        busReq;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        CS;
  logic        WE;
  logic        active;

  uart_bus_master #(
    .CLKS_PER_BIT   (CPB),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (400)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uartRx   (uartRx),
    .uartTx   (uartTx),
    .busReq   (busReq),
    .busGrant (busGrant),
    .AB       (AB),
    .DO       (DO),
    .DI       (DI),
    .CS       (CS),
    .WE       (WE),
    .active   (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus observer and peripheral model: grant 3 cycles after request, read data one cycle after CS.
  int          cs_cnt = 0;
  int          req_rise = 0;
  logic [15:0] cs_ab = '0;
  logic [7:0]  cs_do = '0;
  logic        cs_we = 1'b0;
  logic        cs_req = 1'b0;
  logic        req_prev = 1'b0;
  logic        cs_rd = 1'b0;
  bit          gnt_en = 1'b1;
  int          req_age = 0;

  always @(negedge clk) begin
    if (CS === 1'b1) begin
      cs_cnt++;
      cs_ab  = AB;
      cs_do  = DO;
      cs_we  = WE;
      cs_req = busReq;
    end
    if (busReq && !req_prev) req_rise++;
    req_prev = busReq;
    cs_rd = (CS === 1'b1) && (WE === 1'b0);
    if (busReq && gnt_en) begin
      if (req_age >= 3) busGrant = 1'b1;
      req_age++;
    end else begin
      busGrant = 1'b0;
      req_age  = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    DI = cs_rd ? 8'h3C : 8'hEE;
  end

  // UART decoder on uartTx; completed frames with a good stop bit are queued.
  logic [7:0] rsp_fifo[$];
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (uartTx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uartTx;
        end
        repeat (CPB) @(negedge clk);
        if (uartTx === 1'b1) rsp_fifo.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    uartRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uartRx = stop_bit;
    repeat (CPB) @(negedge clk);
    uartRx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp);
    int n = 0;
    while (rsp_fifo.size() == 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (rsp_fifo.size() == 0) check(tag, 32'hDEAD, {24'h0, exp});
    else                      check(tag, {24'h0, rsp_fifo.pop_front()}, {24'h0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int r0;
    int n;

    repeat (3) @(negedge clk);
    check("rst_tx", uartTx, 1);
    check("rst_req", busReq, 0);
    check("rst_cs", CS, 0);
    check("rst_we", WE, 0);
    check("rst_ab", AB, 0);
    check("rst_do", DO, 0);
    check("rst_active", active, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0xA5 to 0x1234.
    c0 = cs_cnt;
    send_byte(8'h57);
    check("wr_active", active, 1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hA5);
    wait_rsp("wr_rsp", 8'h4B);
    check("wr_cs_count", cs_cnt - c0, 1);
    check("wr_ab", cs_ab, 16'h1234);
    check("wr_do", cs_do, 8'hA5);
    check("wr_we", cs_we, 1);
    check("wr_req_at_cs", cs_req, 1);
    check("wr_req_after", busReq, 0);

    // Read from 0x8000.
    c0 = cs_cnt;
    send_byte(8'h52);
    send_byte(8'h80);
    send_byte(8'h00);
    wait_rsp("rd_rsp", 8'h3C);
    check("rd_cs_count", cs_cnt - c0, 1);
    check("rd_ab", cs_ab, 16'h8000);
    check("rd_we", cs_we, 0);

    // Unknown command, then a normal read.
    r0 = req_rise;
    send_byte(8'h41);
    wait_rsp("bad_rsp", 8'h3F);
    check("bad_no_req", req_rise - r0, 0);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_rsp("bad_next_rsp", 8'h3C);
    check("bad_next_ab", cs_ab, 16'h0001);

    // Abandoned write frame times out, next read works.
    c0 = cs_cnt;
    send_byte(8'h57);
    send_byte(8'h12);
    repeat (385) @(negedge clk);
    check("to_active_before", active, 1);
    repeat (25) @(negedge clk);
    check("to_active_after", active, 0);
    repeat (90) @(negedge clk);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h02);
    wait_rsp("to_rsp", 8'h3C);
    check("to_cs_count", cs_cnt - c0, 1);
    check("to_we", cs_we, 0);
    check("to_ab", cs_ab, 16'h0002);

    // Framing error and a short glitch are both ignored.
    c0 = cs_cnt;
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    uartRx = 1'b0;
    repeat (2) @(negedge clk);
    uartRx = 1'b1;
    repeat (20) @(negedge clk);
    check("frm_idle", active, 0);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hFF);
    wait_rsp("frm_rsp", 8'h4B);
    check("frm_cs_count", cs_cnt - c0, 1);
    check("frm_ab", cs_ab, 16'h0010);
    check("frm_do", cs_do, 8'hFF);
    check("frm_we", cs_we, 1);

    // Reset while waiting for grant: no bus cycle afterwards.
    gnt_en = 1'b0;
    c0 = cs_cnt;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h03);
    n = 0;
    while (!busReq && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst1_req_pre", busReq, 1);
    reset = 1'b1;
    #1;
    check("rst1_req", busReq, 0);
    check("rst1_cs", CS, 0);
    check("rst1_tx", uartTx, 1);
    check("rst1_active", active, 0);
    gnt_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("rst1_no_cycle", cs_cnt - c0, 0);
    check("rst1_req_post", busReq, 0);

    // Reset in the middle of a response byte.
    send_byte(8'h41);
    n = 0;
    while (uartTx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst2_tx_started", uartTx, 0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2_tx", uartTx, 1);
    check("rst2_active", active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    rsp_fifo.delete();
    check("rst2_tx_idle", uartTx, 1);

    // Normal operation resumes after reset.
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h04);
    wait_rsp("post_rst_rsp", 8'h3C);
    check("post_rst_ab", cs_ab, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
